// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for mult/multu/div/divu/mthi/mtlo.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, plus a one-cycle sign fix-up.
module mdu_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [DATA_W-1:0]   dvsr;     // multiplicand or divisor magnitude
  logic [DATA_W-1:0]   a_raw;
  logic                is_div;
  logic                sign_q;
  logic                sign_r;
  logic                dbz;

  logic                op_signed;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_sh;
  logic                div_ok;
  logic [DATA_W-1:0]   div_rem;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Operand capture magnitudes and per-cycle datapath steps.
  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[DATA_W-1]) ? (~a + 1'b1) : a;
    b_mag     = (op_signed && b[DATA_W-1]) ? (~b + 1'b1) : b;

    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, dvsr} : {(DATA_W+1){1'b0}});
    mul_next  = {mul_sum, acc[DATA_W-1:1]};

    div_sh    = acc[2*DATA_W-1:DATA_W-1];
    div_ok    = div_sh >= {1'b0, dvsr};
    div_rem   = div_sh[DATA_W-1:0] - dvsr;
    div_next  = {(div_ok ? div_rem : div_sh[DATA_W-1:0]), acc[DATA_W-2:0], div_ok};

    prod_fix  = sign_q ? (~acc + 1'b1) : acc;
    quo_fix   = sign_q ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
    rem_fix   = sign_r ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      dvsr        <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      // Flush aborts any operation and also suppresses a same-cycle start.
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (op)
                3'b000, 3'b001: begin
                  state  <= MUL;
                  busy   <= 1'b1;
                  cnt    <= CNT_LAST;
                  acc    <= {{DATA_W{1'b0}}, b_mag};
                  dvsr   <= a_mag;
                  a_raw  <= a;
                  is_div <= 1'b0;
                  dbz    <= 1'b0;
                  sign_q <= op_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                  sign_r <= op_signed & a[DATA_W-1];
                end
                3'b010, 3'b011: begin
                  state  <= DIV;
                  busy   <= 1'b1;
                  cnt    <= CNT_LAST;
                  acc    <= {{DATA_W{1'b0}}, a_mag};
                  dvsr   <= b_mag;
                  a_raw  <= a;
                  is_div <= 1'b1;
                  dbz    <= (b == '0);
                  sign_q <= op_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                  sign_r <= op_signed & a[DATA_W-1];
                end
                3'b100:  hi <= a;
                3'b101:  lo <= a;
                default: ;
              endcase
            end
          end
          MUL: begin
            acc <= mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*DATA_W-1:DATA_W];
              lo <= prod_fix[DATA_W-1:0];
            end else if (dbz) begin
              // Divide by zero returns the raw dividend and an all-ones quotient.
              hi          <= a_raw;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, random ops vs. arithmetic model, corner sequences.
module tb_mdu_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  mdu_seq #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the instruction semantics.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic [63:0] p;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        h = p[63:32];
        l = p[31:0];
      end
      3'd1: begin
        p = {32'd0, x} * {32'd0, y};
        h = p[63:32];
        l = p[31:0];
      end
      3'd2, 3'd3: begin
        if (y == 0) begin
          h = x; l = '1; z = 1'b1;
        end else if (o == 3'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = '0; l = 32'h8000_0000;
        end else if (o == 3'd2) begin
          l = 32'($signed(x) / $signed(y));
          h = 32'($signed(x) % $signed(y));
        end else begin
          l = x / y;
          h = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue a mul/div and wait (bounded) for done; returns busy-cycle count.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int bcnt, output bit ok);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) bcnt++;
      @(negedge clk);
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_move(input logic [2:0] o, input logic [W-1:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) m_hi = x; else m_lo = x;
    chk("move_hi", 64'(hi), 64'(m_hi));
    chk("move_lo", 64'(lo), 64'(m_lo));
    chk("move_nobusy", {62'd0, busy, done}, 64'd0);
  endtask

  vec_t vt[$];

  initial begin
    int bc;
    bit ok;
    logic [W-1:0] eh, el;
    logic ez;
    logic [W-1:0] sh, sl;

    vt.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    vt.push_back('{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
    vt.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vt.push_back('{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0});
    vt.push_back('{3'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1});
    vt.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vt.push_back('{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
    vt.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    vt.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", {busy, done, div_by_zero, hi, lo}, 67'd0);
    rst = 1'b0;

    // Directed table
    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, bc, ok);
      chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vt[i].hi, vt[i].lo});
      chk($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(vt[i].dbz));
      chk($sformatf("vec%0d_busy_len", i), 64'(bc), 64'd33);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {62'd0, done, div_by_zero}, 64'd0);
      m_hi = vt[i].hi; m_lo = vt[i].lo;
    end

    // mthi/mtlo in idle
    do_move(3'd4, 32'hA5A5_A5A5);
    do_move(3'd5, 32'h5A5A_0F0F);

    // Random ops against the model
    for (int k = 0; k < 40; k++) begin
      logic [2:0] o;
      logic [W-1:0] x, y;
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = '0;
        1, 2:    y = W'($urandom_range(1, 20));
        3:       y = W'(-int'($urandom_range(1, 20)));
        default: y = $urandom;
      endcase
      if (o >= 3'd4) begin
        do_move(o, x);
      end else begin
        ref_op(o, x, y, eh, el, ez);
        do_op(o, x, y, bc, ok);
        chk($sformatf("rnd%0d_op%0d_hilo", k, o), {hi, lo}, {eh, el});
        chk($sformatf("rnd%0d_dbz", k), 64'(div_by_zero), 64'(ez));
        m_hi = eh; m_lo = el;
      end
    end

    // Flush mid-multiply: abort, no done, HI/LO untouched
    sh = hi; sl = lo;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) ok = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(ok), 64'd0);
    chk("flush_hilo", {hi, lo}, {sh, sl});

    // Flush dominates a same-cycle start
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start", {busy, hi}, {1'b0, sh});

    // mthi while busy is ignored
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd33;
    @(negedge clk);
    op = 3'd4; a = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("busy_mthi_done", 64'(ok), 64'd1);
    chk("busy_mthi_ignored", {hi, lo}, {32'd10, 32'd30});

    // Back-to-back: new start in the done cycle
    start = 1'b1; op = 3'd1; a = 32'd123456; b = 32'd789;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("b2b_done", 64'(ok), 64'd1);
    chk("b2b_hilo", {hi, lo}, 64'd97406784);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'hFFFF_0000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {busy, done, div_by_zero, hi, lo}, 67'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'd3, 32'd100, 32'd7, bc, ok);
    chk("post_rst_hilo", {hi, lo}, {32'd2, 32'd14});
    chk("post_rst_busy_len", 64'(bc), 64'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
